// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot decoder with auto-scan.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake anywhere in this block).
package decoder_pkg;

  // Operating mode of the decoder: follow the input index, or walk it automatically
  typedef enum logic {
    DIRECT = 1'b0,
    SCAN   = 1'b1
  } mode_e;

  // Largest supported number of clocks per scan step (divider is at most 24 bits)
  localparam int SCAN_DIV_MAX = 2 ** 24;

  // Bits needed to count 0..v-1, never less than one bit
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_div_cnt.sv
// Scan-rate divider: counts 0..SCAN_DIV-1 while run is high, ticks on the last count.
// Latency: tick is combinational on the registered count (same cycle as count==SCAN_DIV-1).
// Backpressure: run=0 freezes the count in place; clr forces it to zero and wins over run.
module scan_div_cnt
  import decoder_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The step happens on the edge that would otherwise take the count past its last value
  assign tick = run && (cnt_q == LAST);

  // Next count: clear, wrap on tick, increment while running, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered IN_W-to-2^IN_W one-hot decoder with enable and an auto-scan mode (DECODER_ACTIVE_LOW_EN inverts out).
// Latency: 1 cycle from in/ena/scan_en to out and sel_idx; scan steps every SCAN_DIV cycles.
// Backpressure: none; ena=0 blanks out and, while scanning, freezes the divider and index.
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter int IN_W     = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [IN_W-1:0]      in,
  input  logic                 ena,
  input  logic                 scan_en,
  output logic [(2**IN_W)-1:0] out,
  output logic [IN_W-1:0]      sel_idx,
  output logic                 step_pulse
);

  localparam int OUT_W = 2 ** IN_W;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic ACT_LOW = 1'b1;
`else
  localparam logic ACT_LOW = 1'b0;
`endif

  // Pattern driven when no line is selected; XOR-ing with it also applies the polarity
  localparam logic [OUT_W-1:0] OUT_IDLE = ACT_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] ONE_HOT0 = OUT_W'(1);

  mode_e            mode_q;
  mode_e            mode_d;
  logic [IN_W-1:0]  sel_q;
  logic [IN_W-1:0]  sel_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic             pulse_q;
  logic             pulse_d;

  logic             div_clr;
  logic             div_run;
  logic             div_tick;
  logic             line_on;

  // Mode register: simply tracks scan_en one cycle late
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mode_q <= DIRECT;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next mode comes straight from scan_en every cycle
  always_comb begin
    mode_d = scan_en ? SCAN : DIRECT;
  end

  // Divider control: held at zero in direct mode and on the scan-entry edge,
  // counts only while steadily scanning with the outputs enabled
  always_comb begin
    div_clr = !scan_en || (mode_q == DIRECT);
    div_run = scan_en && (mode_q == SCAN) && ena;
  end

  scan_div_cnt #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_div_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (div_clr),
    .run       (div_run),
    .tick      (div_tick)
  );

  // Output-side next values: index, decoded line and step pulse
  always_comb begin
    sel_d   = sel_q;
    pulse_d = 1'b0;
    line_on = 1'b0;
    if (div_clr) begin
      // Direct mode and scan entry both load the index from the input
      sel_d   = in;
      line_on = ena;
    end else if (ena) begin
      // Steady scan: index wraps naturally because OUT_W is a power of two
      line_on = 1'b1;
      if (div_tick) begin
        sel_d   = sel_q + 1'b1;
        pulse_d = 1'b1;
      end
    end
    out_d = (line_on ? (ONE_HOT0 << sel_d) : {OUT_W{1'b0}}) ^ OUT_IDLE;
  end

  // Index, decoded output and step pulse registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sel_q   <= '0;
      out_q   <= OUT_IDLE;
      pulse_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      out_q   <= out_d;
      pulse_q <= pulse_d;
    end
  end

  assign out        = out_q;
  assign sel_idx    = sel_q;
  assign step_pulse = pulse_q;

endmodule

// File: doc/decoder_n_scan.md
Name: decoder_n_scan

Overview:
- Parametrised IN_W-to-2^IN_W one-hot decoder with enable and registered outputs.
- Adds an auto-scan mode: an internal divider walks the active output line across all positions at a fixed rate.
- Drives digit-select lines for multiplexed 7-segment or LED-matrix boards. Also serves as a generic registered address decoder for the lab designs.

Parameters:
- IN_W, 2, width of binary select input; OUT_W = 2**IN_W is derived (localparam, not overridable).
- SCAN_DIV, 50000, sys_clk cycles per scan step; legal range 1..2**24.

Ports:
- sys_clk  input  1  system clock, all logic rising-edge.
- sys_rst_n  input  1  synchronous active-low reset, sampled on sys_clk rising edge.
- in  input  IN_W  binary index for direct mode; scan start index on scan entry.
- ena  input  1  output enable; 0 forces all lines inactive.
- scan_en  input  1  0 = direct mode, 1 = auto-scan mode.
- out  output  OUT_W  one-hot (or all-inactive) decoded lines, registered.
- sel_idx  output  IN_W  index currently driven on out, registered.
- step_pulse  output  1  one-cycle pulse on each scan advance.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge): out=0, sel_idx=0, step_pulse=0, divider=0, state=DIRECT. Reset mid-scan aborts immediately; the next non-reset edge starts from these values.
- States: DIRECT, SCAN. The state register is updated from scan_en every cycle.
- DIRECT state:
  - sel_idx <= in.
  - out <= ena ? (1 << in) : 0.
  - Latency 1 cycle from in/ena to out.
  - step_pulse=0, divider held at 0.
- DIRECT->SCAN (scan_en rises):
  - Same edge: sel_idx <= in, divider <= 0, out <= ena ? (1 << in) : 0.
  - First advance occurs SCAN_DIV cycles later.
- SCAN state, ena=1:
  - Divider counts 0..SCAN_DIV-1.
  - On the edge where divider==SCAN_DIV-1: divider <= 0, sel_idx <= sel_idx+1 mod OUT_W (wraps OUT_W-1 -> 0), out updated to the new one-hot in the same edge, step_pulse <= 1 for exactly that cycle.
  - in is ignored while in SCAN.
- SCAN state, ena=0:
  - Divider and sel_idx freeze, out=0, step_pulse=0.
  - When ena returns to 1, counting resumes from the frozen divider value. out shows the frozen sel_idx one cycle later.
- SCAN->DIRECT (scan_en falls): divider <= 0, step_pulse <= 0, out and sel_idx follow in/ena from that edge.
- SCAN_DIV=1: step every cycle, step_pulse held continuously high while scanning.
- out is never multi-hot; at most one bit is active at any time.
- Divider width = clog2(SCAN_DIV), minimum 1 bit; no overflow past SCAN_DIV-1.

Optional Feature:
- Macro: DECODER_ACTIVE_LOW_EN.
- Defined: out is the bitwise inverse of the active-high value (selected line 0, others 1). Reset value and ena=0 value become all ones. Intended for common-anode digit selects.
- Undefined: active-high out as above.
- sel_idx and step_pulse are unaffected in both cases.

Decomposition:
- Package decoder_pkg:
  - mode enum {DIRECT, SCAN}.
  - clog2 function for divider width.
  - Constant for maximum SCAN_DIV.
- Sub-module scan_div_cnt (parameter SCAN_DIV):
  - Inputs: sys_clk, sys_rst_n, clr, run.
  - Output: tick, asserted when the count equals SCAN_DIV-1 and run=1.
  - Instantiated once.
- Top level holds the state register, index register and one-hot output register.

Test Plan:
- Reset: sys_rst_n=0 for 3 cycles with in=3, ena=1, scan_en=1 -> out=0000, sel_idx=0, step_pulse=0 throughout; first non-reset edge enters SCAN with sel_idx=3, out=1000.
- Direct sweep, IN_W=2: ena=1, in = 0,1,2,3 each held one cycle -> out = 0001, 0010, 0100, 1000, each one cycle after the corresponding in; ena=0 -> out=0000 on the next edge.
- Scan wrap, SCAN_DIV=4: scan_en=1 with in=2 -> out 0100, 1000, 0001, 0010, 0100 changing every 4 cycles; step_pulse high one cycle at each change; sel_idx wraps 3->0.
- Freeze: in SCAN, drop ena for 10 cycles at divider=2 -> out=0000, no step_pulse; restore ena -> next advance exactly 2 cycles after resume (SCAN_DIV=4).
- Mode exit: scan_en falls mid-count with in=1 -> out=0010 next edge, step_pulse stays 0; re-enter scan -> full SCAN_DIV cycles before first step.
- Width/option: IN_W=3, SCAN_DIV=1, DECODER_ACTIVE_LOW_EN defined -> out cycles 11111110, 11111101, ... every cycle; reset value 11111111.
